// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings, FSM states, iteration count and a sign helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4,
        OpMthi  = 3'd5,
        OpMtlo  = 3'd6,
        OpRsvd  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2
    } mdu_state_e;

    localparam int unsigned IterCount = 32;
    localparam logic [4:0]  LastCount = 5'(IterCount - 1);

    // Two's-complement magnitude when neg is set; also used for the final negate.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 unsigned divider datapath: one quotient bit per step.
// Exposes next-step remainder/quotient so the caller can write results on the final step.
module div_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo_next,
    output logic [31:0] rem_next
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        qbit;

    // The dividend shifts out of quo_q into the remainder while quotient bits shift in.
    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        diff     = shifted - {1'b0, dvs_q};
        qbit     = ~diff[32];
        rem_next = qbit ? diff[31:0] : shifted[31:0];
        quo_next = {quo_q[30:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= 32'd0;
            quo_q <= 32'd0;
            dvs_q <= 32'd0;
        end else if (load) begin
            rem_q <= 32'd0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: FSM, EXE stall, sign fix-up and HI/LO registers.
// Define MDU_FAST_MUL_EN for single-cycle MULT/MULTU; otherwise a 32-step shift-add is used.
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_exe,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_exe,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  state;
    logic [4:0]  count;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sgn_q;

    mdu_op_e     op;
    logic        issue;
    logic        issue_iter;
    logic        op_is_mul;
    logic        op_is_div;
    logic        op_signed;
    logic        last;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        neg_rem;
    logic        neg_res;
    logic [31:0] quo_next;
    logic [31:0] rem_next;
    logic [63:0] div_res;
    logic [63:0] done_res;

    assign op        = mdu_op_e'(mdu_op);
    assign op_is_mul = (op == OpMult) || (op == OpMultu);
    assign op_is_div = (op == OpDiv) || (op == OpDivu);
    assign op_signed = (op == OpMult) || (op == OpDiv);
    assign issue     = (state == StIdle) && valid_exe && !flush
                       && (op != OpNone) && (op != OpRsvd);
    assign last      = (count == LastCount);

    assign mag_a = mag32(src_a, op_signed & src_a[31]);
    assign mag_b = mag32(src_b, op_signed & src_b[31]);

`ifdef MDU_FAST_MUL_EN
    assign issue_iter = issue && op_is_div;
`else
    assign issue_iter = issue && (op_is_div || op_is_mul);
`endif

    // The completing cycle (count==31) releases EXE; flush always releases it.
    assign stall_exe = issue_iter || ((state != StIdle) && !last && !flush);

    assign neg_rem = sgn_q & a_q[31];
    assign neg_res = sgn_q & (a_q[31] ^ b_q[31]);

    // Divide-by-zero bypasses the sign fix-up for both signednesses.
    assign div_res = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF}
                                    : {mag32(rem_next, neg_rem), mag32(quo_next, neg_res)};

    div_iter u_div_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (issue && op_is_div),
        .step     ((state == StDiv) && !flush),
        .dividend (mag_a),
        .divisor  (mag_b),
        .quo_next (quo_next),
        .rem_next (rem_next)
    );

`ifdef MDU_FAST_MUL_EN
    logic [63:0] fast_prod;
    logic [63:0] fast_res;

    assign fast_prod = {32'd0, mag_a} * {32'd0, mag_b};
    assign fast_res  = (op_signed & (src_a[31] ^ src_b[31])) ? (~fast_prod + 64'd1) : fast_prod;
    assign done_res  = div_res;
`else
    logic [63:0] prod_q;
    logic [63:0] prod_d;
    logic [31:0] mcand_q;
    logic [32:0] acc_sum;
    logic [63:0] mul_res;

    // prod_q holds {accumulator, remaining multiplier bits}; each step adds then shifts right.
    always_comb begin
        acc_sum = {1'b0, prod_q[63:32]};
        if (prod_q[0]) begin
            acc_sum = {1'b0, prod_q[63:32]} + {1'b0, mcand_q};
        end
        prod_d = {acc_sum, prod_q[31:1]};
    end

    assign mul_res  = neg_res ? (~prod_d + 64'd1) : prod_d;
    assign done_res = (state == StMul) ? mul_res : div_res;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q  <= 64'd0;
            mcand_q <= 32'd0;
        end else if (issue && op_is_mul) begin
            prod_q  <= {32'd0, mag_b};
            mcand_q <= mag_a;
        end else if ((state == StMul) && !flush) begin
            prod_q  <= prod_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= StIdle;
            count <= 5'd0;
            busy  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            sgn_q <= 1'b0;
        end else if (state != StIdle) begin
            // Flush wins over a same-cycle completion: no HI/LO write.
            if (flush) begin
                state <= StIdle;
                busy  <= 1'b0;
                count <= 5'd0;
            end else if (last) begin
                state    <= StIdle;
                busy     <= 1'b0;
                count    <= 5'd0;
                {hi, lo} <= done_res;
            end else begin
                count <= count + 5'd1;
            end
        end else if (issue) begin
            a_q   <= src_a;
            b_q   <= src_b;
            sgn_q <= op_signed;
            unique case (op)
                OpMthi: hi <= src_a;
                OpMtlo: lo <= src_a;
                OpDiv, OpDivu: begin
                    state <= StDiv;
                    busy  <= 1'b1;
                    count <= 5'd0;
                end
                OpMult, OpMultu: begin
`ifdef MDU_FAST_MUL_EN
                    {hi, lo} <= fast_res;
`else
                    state <= StMul;
                    busy  <= 1'b1;
                    count <= 5'd0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the driver queues expected HI/LO and stall counts,
// a monitor checks them when the instruction leaves EXE.
module tb_mdu_ctrl;

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

`ifdef MDU_FAST_MUL_EN
    localparam int MulStall = 0;
`else
    localparam int MulStall = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_exe;
    logic [2:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_exe;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        string       nm;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mon_stalls = 0;
    exp_t mon_e;

    mdu_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_exe (valid_exe),
        .mdu_op    (mdu_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .stall_exe (stall_exe),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issues one op, holds it in EXE until released, scrambling inputs while busy.
    task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el, input int st,
                            input string nm);
        exp_t e;
        int   n;
        e.nm = nm;
        e.hi = eh;
        e.lo = el;
        e.stalls = st;
        sb.push_back(e);
        valid_exe = 1'b1;
        mdu_op    = op;
        src_a     = a;
        src_b     = b;
        @(negedge clk);
        if (stall_exe) begin
            @(posedge clk);
            #1;
            src_a  = ~a ^ 32'h5A5A_0000;
            src_b  = 32'd0;
            mdu_op = OpMthi;
            n = 0;
            @(negedge clk);
            while (stall_exe && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (stall_exe) begin
                total++;
                bad++;
                $display("FAIL %s timeout: stall_exe still 1 want 0", nm);
            end
        end
        @(posedge clk);
        #1;
        valid_exe = 1'b0;
        mdu_op    = 3'd0;
    endtask

    // Issues an op and flushes it when the iteration counter reaches k.
    task automatic flush_at(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int k, input logic [31:0] ph, input logic [31:0] pl,
                            input string nm);
        valid_exe = 1'b1;
        mdu_op    = op;
        src_a     = a;
        src_b     = b;
        repeat (k + 1) @(posedge clk);
        #1;
        flush = 1'b1;
        check({nm, " busy before flush"}, {63'd0, busy}, 64'd1);
        @(negedge clk);
        check({nm, " stall during flush"}, {63'd0, stall_exe}, 64'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        valid_exe = 1'b0;
        mdu_op    = 3'd0;
        check({nm, " busy after flush"}, {63'd0, busy}, 64'd0);
        check({nm, " hi kept"}, {32'd0, hi}, {32'd0, ph});
        check({nm, " lo kept"}, {32'd0, lo}, {32'd0, pl});
    endtask

    // Monitor: counts stall cycles of the EXE instruction, checks HI/LO after it leaves.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && valid_exe && !flush && mdu_op != 3'd0 && mdu_op != 3'd7) begin
                if (stall_exe) begin
                    mon_stalls++;
                end else begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL retire: got unexpected op %0d want none", mdu_op);
                    end else begin
                        mon_e = sb.pop_front();
                        check({mon_e.nm, " stalls"}, 64'(mon_stalls), 64'(mon_e.stalls));
                        @(posedge clk);
                        #1;
                        check({mon_e.nm, " hi"}, {32'd0, hi}, {32'd0, mon_e.hi});
                        check({mon_e.nm, " lo"}, {32'd0, lo}, {32'd0, mon_e.lo});
                    end
                    mon_stalls = 0;
                end
            end else begin
                mon_stalls = 0;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        valid_exe = 1'b0;
        mdu_op    = 3'd0;
        src_a     = 32'd0;
        src_b     = 32'd0;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset stall", {63'd0, stall_exe}, 64'd0);
        @(posedge clk);
        #1;

        issue_op(OpMthi, 32'h1234, 32'd0, 32'h1234, 32'h0, 0, "mthi");
        issue_op(OpMtlo, 32'h5678, 32'd0, 32'h1234, 32'h5678, 0, "mtlo");
        issue_op(OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 32, "divu 100/7");
        issue_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32, "div -7/2");
        issue_op(OpDiv, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 32, "div 5/0");
        issue_op(OpDiv, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32, "div -9/0");
        issue_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32, "div min/-1");
        issue_op(OpDiv, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 32, "div 7/-2");
        issue_op(OpDivu, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 32, "divu max/16");
        issue_op(OpMult, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, MulStall,
                 "mult -1x3");
        issue_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
                 MulStall, "multu max^2");
        issue_op(OpMult, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, MulStall,
                 "mult 7x-6");

        flush_at(OpDivu, 32'd9, 32'd3, 10, 32'hFFFF_FFFF, 32'hFFFF_FFD6, "flush@10");
        issue_op(OpDivu, 32'd9, 32'd3, 32'd0, 32'd3, 32, "divu 9/3");
        flush_at(OpDiv, 32'd100, 32'd7, 31, 32'd0, 32'd3, "flush@31");
        issue_op(OpDiv, 32'd100, 32'd7, 32'd2, 32'd14, 32, "div 100/7");

        // Reset in the middle of an iteration at count 20.
        valid_exe = 1'b1;
        mdu_op    = OpDivu;
        src_a     = 32'd100;
        src_b     = 32'd7;
        repeat (21) @(posedge clk);
        #1;
        check("busy before reset", {63'd0, busy}, 64'd1);
        rst_n     = 1'b0;
        valid_exe = 1'b0;
        mdu_op    = 3'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midreset hi", {32'd0, hi}, 64'd0);
        check("midreset lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        check("midreset busy", {63'd0, busy}, 64'd0);
        check("midreset stall", {63'd0, stall_exe}, 64'd0);
        @(posedge clk);
        #1;
        issue_op(OpMtlo, 32'hCAFE, 32'd0, 32'd0, 32'hCAFE, 0, "mtlo after reset");

        repeat (3) @(posedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
